// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the vending FSM (master) and the
// change dispenser (slave).
interface change_dispenser_if;
  logic       start;
  logic [7:0] amount;
  logic       refill;
  logic [7:0] refill_ten;
  logic [7:0] refill_five;
  logic       eject_10;
  logic       eject_5;
  logic       busy;
  logic       done;
  logic       short;
  logic [7:0] residual;
  logic [7:0] ten_count;
  logic [7:0] five_count;

  modport master (
    output start, amount, refill, refill_ten, refill_five,
    input  eject_10, eject_5, busy, done, short, residual, ten_count, five_count
  );

  modport slave (
    input  start, amount, refill, refill_ten, refill_five,
    output eject_10, eject_5, busy, done, short, residual, ten_count, five_count
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout (10 first, then 5) with spaced eject pulses, tube
// inventory tracking and reporting of any unpaid residual.
module change_dispenser #(
  parameter int unsigned GAP       = 4,
  parameter logic [7:0]  INIT_TEN  = 8'd20,
  parameter logic [7:0]  INIT_FIVE = 8'd20
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);

  localparam int unsigned   CW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_GAP} state_e;

  state_e        state_q;
  logic [7:0]    remaining_q;
  logic [7:0]    ten_q;
  logic [7:0]    five_q;
  logic [7:0]    residual_q;
  logic [CW-1:0] gap_q;
  logic          eject_10_q;
  logic          eject_5_q;
  logic          busy_q;
  logic          done_q;
  logic          short_q;
  logic [7:0]    ten_refill_d;
  logic [7:0]    five_refill_d;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_comb begin
    ten_refill_d  = sat_add8(ten_q, bus.refill_ten);
    five_refill_d = sat_add8(five_q, bus.refill_five);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= 8'd0;
      ten_q       <= INIT_TEN;
      five_q      <= INIT_FIVE;
      residual_q  <= 8'd0;
      gap_q       <= '0;
      eject_10_q  <= 1'b0;
      eject_5_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      eject_10_q <= 1'b0;
      eject_5_q  <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Refill lands in the same edge as start, so SELECT sees the new counts.
          if (bus.refill) begin
            ten_q  <= ten_refill_d;
            five_q <= five_refill_d;
          end
          if (bus.start) begin
            remaining_q <= bus.amount;
            busy_q      <= 1'b1;
            short_q     <= 1'b0;
            residual_q  <= 8'd0;
            state_q     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (remaining_q >= 8'd10 && ten_q != 8'd0) begin
            eject_10_q  <= 1'b1;
            ten_q       <= ten_q - 8'd1;
            remaining_q <= remaining_q - 8'd10;
            gap_q       <= GAP_LOAD;
            state_q     <= S_GAP;
          end else if (remaining_q >= 8'd5 && five_q != 8'd0) begin
            eject_5_q   <= 1'b1;
            five_q      <= five_q - 8'd1;
            remaining_q <= remaining_q - 8'd5;
            gap_q       <= GAP_LOAD;
            state_q     <= S_GAP;
          end else begin
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            residual_q <= remaining_q;
            short_q    <= (remaining_q != 8'd0);
            state_q    <= S_IDLE;
          end
        end
        S_GAP: begin
          // GAP cycles spent here, so consecutive pulses are GAP+1 apart.
          if (gap_q == '0) begin
            state_q <= S_SELECT;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.eject_10   = eject_10_q;
  assign bus.eject_5    = eject_5_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.short      = short_q;
  assign bus.residual   = residual_q;
  assign bus.ten_count  = ten_q;
  assign bus.five_count = five_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model predicts every
// eject/done event and its edge; a negedge monitor pops and compares them.
module tb_change_dispenser;

  localparam int GAP = 4;

  typedef struct {
    int cyc;
    int code;  // 1 = eject_10, 2 = eject_5, 3 = done
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  change_dispenser_if bus ();

  change_dispenser #(
    .GAP      (GAP),
    .INIT_TEN (8'd0),
    .INIT_FIVE(8'd1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  edge_n   = 0;
  int  ev_seen  = 0;
  int  m_ten, m_five, m_res;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    ev_t e;
    int  code;
    if (bus.eject_10 && bus.eject_5) check_val("both_ejects", 1, 0);
    if (bus.eject_10 || bus.eject_5 || bus.done) begin
      code = bus.done ? 3 : (bus.eject_10 ? 1 : 2);
      ev_seen++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_event", code, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("event_code", code, e.code);
        check_val("event_edge", edge_n, e.cyc);
        check_val("busy_at_event", int'(bus.busy), (code == 3) ? 0 : 1);
      end
    end
  end

  // Drives one start (optionally with a same-cycle refill) and queues the predicted events.
  task automatic launch(input int amt, input bit do_ref, input int rt, input int rf);
    int e0, rem, k;
    ev_t e;
    bus.start       = 1'b1;
    bus.amount      = amt[7:0];
    bus.refill      = do_ref;
    bus.refill_ten  = rt[7:0];
    bus.refill_five = rf[7:0];
    if (do_ref) begin
      m_ten  = sat8(m_ten + rt);
      m_five = sat8(m_five + rf);
    end
    e0  = edge_n + 1;
    rem = amt;
    k   = 0;
    while (1) begin
      e.cyc = e0 + 1 + k * (GAP + 1);
      if (rem >= 10 && m_ten > 0) begin
        e.code = 1; m_ten--; rem -= 10;
      end else if (rem >= 5 && m_five > 0) begin
        e.code = 2; m_five--; rem -= 5;
      end else begin
        break;
      end
      exp_q.push_back(e);
      k++;
    end
    e.code = 3;
    exp_q.push_back(e);
    m_res = rem;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.refill = 1'b0;
    check_val("busy_after_start", int'(bus.busy), 1);
    check_val("short_cleared", int'(bus.short), 0);
    check_val("residual_cleared", int'(bus.residual), 0);
  endtask

  task automatic run_payout(input int amt, input bit do_ref, input int rt, input int rf,
                            input bit inject);
    int wait_n;
    launch(amt, do_ref, rt, rf);
    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 300) begin
      if (inject && wait_n == 2) begin
        bus.start = 1'b1; bus.amount = 8'd50;
        bus.refill = 1'b1; bus.refill_ten = 8'd9; bus.refill_five = 8'd9;
      end else begin
        bus.start = 1'b0; bus.refill = 1'b0;
      end
      @(negedge clk);
      wait_n++;
    end
    bus.start  = 1'b0;
    bus.refill = 1'b0;
    if (exp_q.size() > 0) begin
      check_val("payout_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
    check_val("busy_idle", int'(bus.busy), 0);
    check_val("residual", int'(bus.residual), m_res);
    check_val("short", int'(bus.short), (m_res != 0) ? 1 : 0);
    check_val("ten_count", int'(bus.ten_count), m_ten);
    check_val("five_count", int'(bus.five_count), m_five);
  endtask

  task automatic do_refill(input int rt, input int rf);
    bus.refill      = 1'b1;
    bus.refill_ten  = rt[7:0];
    bus.refill_five = rf[7:0];
    m_ten  = sat8(m_ten + rt);
    m_five = sat8(m_five + rf);
    @(negedge clk);
    bus.refill = 1'b0;
    check_val("refill_ten", int'(bus.ten_count), m_ten);
    check_val("refill_five", int'(bus.five_count), m_five);
  endtask

  initial begin
    int e0, guard, seen_base;
    reset = 1'b1;
    bus.start = 1'b0; bus.amount = 8'd0; bus.refill = 1'b0;
    bus.refill_ten = 8'd0; bus.refill_five = 8'd0;
    repeat (3) @(negedge clk);
    check_val("rst_eject_10", int'(bus.eject_10), 0);
    check_val("rst_eject_5", int'(bus.eject_5), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_done", int'(bus.done), 0);
    check_val("rst_short", int'(bus.short), 0);
    check_val("rst_residual", int'(bus.residual), 0);
    check_val("rst_ten", int'(bus.ten_count), 0);
    check_val("rst_five", int'(bus.five_count), 1);
    m_ten = 0; m_five = 1;
    reset = 1'b0;
    @(negedge clk);

    run_payout(20, 0, 0, 0, 0);      // one 5, residual 15
    do_refill(1, 20);
    run_payout(30, 0, 0, 0, 0);      // 10 then four 5s
    do_refill(20, 4);
    run_payout(35, 0, 0, 0, 0);      // 10,10,10,5
    run_payout(23, 0, 0, 0, 0);      // residual 3
    run_payout(0, 0, 0, 0, 0);       // clears short/residual, done at E1
    run_payout(15, 0, 0, 0, 1);      // start/refill pulsed while busy
    run_payout(10, 1, 0, 3, 0);      // refill in the start cycle
    do_refill(250 - m_ten, 0);
    do_refill(10, 0);                // saturates at 255
    do_refill(0, 250);

    // Reset one cycle after the second pulse of a 35 payout.
    launch(35, 0, 0, 0);
    e0 = edge_n;
    guard = 0;
    while (edge_n < e0 + 6 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_ten = 0; m_five = 1;
    seen_base = ev_seen;
    check_val("abort_eject_10", int'(bus.eject_10), 0);
    check_val("abort_eject_5", int'(bus.eject_5), 0);
    check_val("abort_busy", int'(bus.busy), 0);
    check_val("abort_done", int'(bus.done), 0);
    check_val("abort_short", int'(bus.short), 0);
    check_val("abort_residual", int'(bus.residual), 0);
    check_val("abort_ten", int'(bus.ten_count), 0);
    check_val("abort_five", int'(bus.five_count), 1);
    repeat (40) @(negedge clk);
    check_val("events_after_abort", ev_seen - seen_base, 0);
    check_val("abort_busy_later", int'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out change by emitting one-cycle coin-eject pulses toward the ₹10 and ₹5 coin tubes. It is the payout counterpart of the coin-accepting balance logic. The vending FSM hands it a change amount with a start pulse; the dispenser pays greedily (₹10 first, then ₹5), tracks tube inventory, spaces pulses for the eject mechanism, and reports any unpaid residual.

## Interface
Parameters:
- `GAP`, default 4: idle cycles after each eject pulse (≥1) before the next coin decision.
- `INIT_TEN`, default 8'd20: ₹10 tube count loaded on reset.
- `INIT_FIVE`, default 8'd20: ₹5 tube count loaded on reset.

Ports:
- `clk` in 1: single clock; all logic is on the posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a payout; accepted only in IDLE.
- `amount` in 8: change in rupees; sampled on the accepted `start` edge.
- `refill` in 1: in IDLE only, adds `refill_ten` and `refill_five` to the inventory.
- `refill_ten` in 8: number of ₹10 coins added.
- `refill_five` in 8: number of ₹5 coins added.
- `eject_10` out 1: one-cycle pulse that ejects one ₹10 coin.
- `eject_5` out 1: one-cycle pulse that ejects one ₹5 coin.
- `busy` out 1: high while a payout is in progress.
- `done` out 1: one-cycle pulse when the payout finishes.
- `short` out 1: high when the last payout left a nonzero residual.
- `residual` out 8: rupees left unpaid by the last payout.
- `ten_count` out 8: current ₹10 tube inventory.
- `five_count` out 8: current ₹5 tube inventory.

## Operation
- **Reset values:**
  - `eject_10`, `eject_5`, `busy`, `done`, `short`, `residual` = 0.
  - `ten_count` = INIT_TEN; `five_count` = INIT_FIVE.
  - State = IDLE; internal `remaining` = 0; gap counter = 0.
- **States:** IDLE, SELECT, GAP.
- **IDLE:**
  - `start` → `remaining` ← `amount`, `busy` ← 1, `short` ← 0, `residual` ← 0, next state SELECT.
  - `start` while not in IDLE is ignored. It is not queued.
- **SELECT** (one cycle, priority order):
  - `remaining` ≥ 10 and `ten_count` > 0: `eject_10` ← 1, `ten_count` −1, `remaining` −10, → GAP.
  - Else `remaining` ≥ 5 and `five_count` > 0: `eject_5` ← 1, `five_count` −1, `remaining` −5, → GAP.
  - Else finish: `done` ← 1, `busy` ← 0, `residual` ← `remaining`, `short` ← (`remaining` ≠ 0), → IDLE.
- **GAP:**
  - Eject pulses clear after one cycle.
  - Stays GAP cycles total, then → SELECT.
  - `start` and `refill` are ignored throughout.
- **Fallback:** when ₹10 coins run out, ₹5 coins cover the remainder.
- **Non-multiples of 5:** the remainder below 5 is never paid. It appears in `residual` with `short` = 1.
- **Arithmetic:**
  - `remaining` never underflows, because every subtract is guarded by the compare.
  - Inventory decrements are guarded by count > 0.
- **Refill:**
  - Each count saturates at 255; refill ignored unless in IDLE.
  - `refill` and `start` in the same IDLE cycle: refill is applied, start is accepted, and SELECT sees the updated counts.
- **Output hold:** `short` and `residual` hold until the next accepted `start`.
- **Reset mid-payout:** aborts immediately. All outputs go to reset values (inventory reloads INIT values), and no further pulses are issued.

## Timing
- All outputs are registered.
- Edge numbering: `start` is sampled at edge E0; `busy` = 1 after E0.
- Coin k (k = 0,1,…) eject pulse is asserted at edge E1 + k·(GAP+1) and is high for exactly one cycle.
- Pulse spacing is GAP+1 cycles; `eject_10` and `eject_5` are never high together.
- For a payout of N coins, `done` is asserted at edge E1 + N·(GAP+1), and `busy` falls at that same edge.
- New `start` is accepted from the cycle after `done`.
- `amount` = 0 → `done` at E1, no pulses.

## Test plan
- GAP=4, default inventory, `amount`=35:
  - `eject_10` at E1, E6, E11; `eject_5` at E16; `done` at E21.
  - `residual`=0, `short`=0, `ten_count`=17, `five_count`=19.
- Refill raises `ten_count` only to 1 (INIT_TEN=0), `amount`=30:
  - One `eject_10` at E1, then `eject_5` at E6, E11, E16, E21.
  - `done` at E26; `ten_count`=0; `five_count`=16.
- `amount`=23:
  - `eject_10` at E1, E6; `done` at E11.
  - `residual`=3, `short`=1. Next `start` clears both at its edge.
- INIT_TEN=0, INIT_FIVE=1, `amount`=20:
  - Single `eject_5` at E1; `done` at E6.
  - `residual`=15, `short`=1, `five_count`=0.
- `amount`=0:
  - `done` at E1, no pulses.
  - Also: `start` and `refill` pulsed while `busy` → ignored (counts and sequence unchanged).
  - Also: `refill_ten`=10 with `ten_count`=250 in IDLE → 255.
- `reset` asserted one cycle after the 2nd pulse of a 35 payout:
  - All outputs 0 next edge; counts = INIT.
  - No further eject pulses; `done` never asserts.
